vga_glyph_seq: RTL and testbench



---
 rtl/vga_glyph_seq_if.sv | 34 +++
 rtl/vga_glyph_seq.sv | 125 ++++++++++++
 tb/tb_vga_glyph_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_glyph_seq_if.sv
// ============================================================================
// Module  : vga_glyph_seq_if
// Brief   : Glyph sequencer bus: start request, glyph memory port, pixel stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface vga_glyph_seq_if;
    logic       start;
    logic [3:0] code;
    logic       busy;
    logic [4:0] ra;
    logic [7:0] rd;
    logic       px;
    logic [2:0] pxrow;
    logic [1:0] pxcol;
    logic       pxvalid;
    logic       pxready;
    logic       pxlast;

    // Renderer / memory side
    modport master (
        output start, code, rd, pxready,
        input  busy, ra, px, pxrow, pxcol, pxvalid, pxlast
    );

    // Sequencer side
    modport slave (
        input  start, code, rd, pxready,
        output busy, ra, px, pxrow, pxcol, pxvalid, pxlast
    );
endinterface

`default_nettype wire

// File: rtl/vga_glyph_seq.sv
// ============================================================================
// Module  : vga_glyph_seq
// Brief   : Fetches one 3x5 glyph (two bytes) and streams its pixels in raster
//           order over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_glyph_seq #(
    parameter logic [4:0] BASE   = 5'd0,
    parameter bit         INVERT = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vga_glyph_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH0 = 2'd1,
        ST_FETCH1 = 2'd2,
        ST_SHIFT  = 2'd3
    } state_t;

    localparam logic [3:0] c_last_k = 4'd14;

    state_t      r_state;
    logic [3:0]  r_code;
    logic [7:0]  r_hi;
    logic [13:0] r_bm;
    logic [3:0]  r_k;
    logic        r_busy;
    logic        r_px;
    logic [2:0]  r_pxrow;
    logic [1:0]  r_pxcol;
    logic        r_pxvalid;
    logic        r_pxlast;
    logic [4:0]  w_ra;

    // Address depends only on registered state and latched code; wraps mod 32.
    always_comb begin
        w_ra = BASE;
        if (r_state == ST_FETCH0 || r_state == ST_FETCH1) begin
            w_ra = BASE + {r_code, (r_state == ST_FETCH1)};
        end
    end

    // r_bm holds the pixels not yet presented; r_bm[13] is the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_code    <= 4'd0;
            r_hi      <= 8'd0;
            r_bm      <= 14'd0;
            r_k       <= 4'd0;
            r_busy    <= 1'b0;
            r_px      <= 1'b0;
            r_pxrow   <= 3'd0;
            r_pxcol   <= 2'd0;
            r_pxvalid <= 1'b0;
            r_pxlast  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_code  <= bus.code;
                        r_busy  <= 1'b1;
                        r_state <= ST_FETCH0;
                    end
                end
                ST_FETCH0: begin
                    r_hi    <= bus.rd;
                    r_state <= ST_FETCH1;
                end
                ST_FETCH1: begin
                    r_bm      <= {r_hi[6:0], bus.rd[7:1]};
                    r_k       <= 4'd0;
                    r_px      <= r_hi[7] ^ INVERT;
                    r_pxrow   <= 3'd0;
                    r_pxcol   <= 2'd0;
                    r_pxvalid <= 1'b1;
                    r_pxlast  <= 1'b0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bus.pxready) begin
                        if (r_k == c_last_k) begin
                            r_busy    <= 1'b0;
                            r_pxvalid <= 1'b0;
                            r_pxlast  <= 1'b0;
                            r_px      <= 1'b0;
                            r_pxrow   <= 3'd0;
                            r_pxcol   <= 2'd0;
                            r_k       <= 4'd0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_k      <= r_k + 4'd1;
                            r_px     <= r_bm[13] ^ INVERT;
                            r_bm     <= {r_bm[12:0], 1'b0};
                            r_pxlast <= (r_k == c_last_k - 4'd1);
                            if (r_pxcol == 2'd2) begin
                                r_pxcol <= 2'd0;
                                r_pxrow <= r_pxrow + 3'd1;
                            end else begin
                                r_pxcol <= r_pxcol + 2'd1;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.ra      = w_ra;
    assign bus.px      = r_px;
    assign bus.pxrow   = r_pxrow;
    assign bus.pxcol   = r_pxcol;
    assign bus.pxvalid = r_pxvalid;
    assign bus.pxlast  = r_pxlast;

endmodule

`default_nettype wire

// File: tb/tb_vga_glyph_seq.sv
// ============================================================================
// Module  : tb_vga_glyph_seq
// Brief   : Bench for vga_glyph_seq with three parameterisations sharing a ROM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_glyph_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] rom [32];
    logic [2:0] t_start;
    logic [2:0] t_ready;
    logic [3:0] t_code [3];

    wire [2:0] w_busy;
    wire [2:0] w_px;
    wire [2:0] w_pxvalid;
    wire [2:0] w_pxlast;
    wire [4:0] w_ra  [3];
    wire [2:0] w_row [3];
    wire [1:0] w_col [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0: defaults, 1: BASE=30 (wrap), 2: INVERT=1
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            vga_glyph_seq_if bus ();
            assign bus.start   = t_start[g];
            assign bus.code    = t_code[g];
            assign bus.pxready = t_ready[g];
            assign bus.rd      = rom[bus.ra];
            assign w_busy[g]    = bus.busy;
            assign w_px[g]      = bus.px;
            assign w_pxvalid[g] = bus.pxvalid;
            assign w_pxlast[g]  = bus.pxlast;
            assign w_ra[g]      = bus.ra;
            assign w_row[g]     = bus.pxrow;
            assign w_col[g]     = bus.pxcol;
            vga_glyph_seq #(
                .BASE   (g == 1 ? 5'd30 : 5'd0),
                .INVERT (g == 2 ? 1'b1 : 1'b0)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus)
            );
        end
    endgenerate

    function automatic int dbase(input int d);
        return (d == 1) ? 30 : 0;
    endfunction

    function automatic bit dinv(input int d);
        return (d == 2);
    endfunction

    // Reference: bitmap is the high byte followed by the top 7 bits of the low byte.
    function automatic logic [14:0] exp_bm(input int d, input logic [3:0] cd);
        int a;
        logic [7:0] hi;
        logic [7:0] lo;
        a  = (dbase(d) + 2 * int'(cd)) % 32;
        hi = rom[a];
        lo = rom[(a + 1) % 32];
        return {hi, lo[7:1]};
    endfunction

    // Caller must be at a falling edge with instance d idle. mode: 0 ready,
    // 1 three-cycle stall at k=4, 2 random ready. noise pulses start mid-glyph.
    task automatic run_glyph(input int d, input logic [3:0] cd, input int mode,
                             input bit noise, output int cyc);
        logic [14:0] bm;
        int k;
        int stalls;
        int ahi;
        bit r;
        bm  = exp_bm(d, cd);
        ahi = (dbase(d) + 2 * int'(cd)) % 32;
        n_tests++; if (w_busy[d] !== 1'b0) begin n_fail++; $display("FAIL idle_busy d=%0d got %0d want 0", d, w_busy[d]); end
        n_tests++; if (w_ra[d] !== 5'(dbase(d))) begin n_fail++; $display("FAIL idle_ra d=%0d got %0d want %0d", d, w_ra[d], dbase(d)); end
        t_start[d] = 1'b1;
        t_code[d]  = cd;
        @(negedge clk);
        t_start[d] = noise ? 1'($urandom % 2) : 1'b0;
        t_code[d]  = 4'($urandom);
        n_tests++; if (w_busy[d] !== 1'b1) begin n_fail++; $display("FAIL fetch_busy d=%0d got %0d want 1", d, w_busy[d]); end
        n_tests++; if (w_pxvalid[d] !== 1'b0) begin n_fail++; $display("FAIL fetch_valid d=%0d got %0d want 0", d, w_pxvalid[d]); end
        n_tests++; if (w_ra[d] !== 5'(ahi)) begin n_fail++; $display("FAIL ra_hi d=%0d got %0d want %0d", d, w_ra[d], ahi); end
        @(negedge clk);
        n_tests++; if (w_ra[d] !== 5'((ahi + 1) % 32)) begin n_fail++; $display("FAIL ra_lo d=%0d got %0d want %0d", d, w_ra[d], (ahi + 1) % 32); end
        k = 0; cyc = 0; stalls = 0;
        while (k < 15 && cyc < 200) begin
            @(negedge clk);
            n_tests++; if (w_pxvalid[d] !== 1'b1) begin n_fail++; $display("FAIL pxvalid d=%0d k=%0d got %0d want 1", d, k, w_pxvalid[d]); end
            n_tests++; if (w_busy[d] !== 1'b1) begin n_fail++; $display("FAIL shift_busy d=%0d k=%0d got %0d want 1", d, k, w_busy[d]); end
            n_tests++; if (w_px[d] !== (bm[14 - k] ^ dinv(d))) begin n_fail++; $display("FAIL px d=%0d k=%0d got %0d want %0d", d, k, w_px[d], bm[14 - k] ^ dinv(d)); end
            n_tests++; if (w_row[d] !== 3'(k / 3)) begin n_fail++; $display("FAIL pxrow d=%0d k=%0d got %0d want %0d", d, k, w_row[d], k / 3); end
            n_tests++; if (w_col[d] !== 2'(k % 3)) begin n_fail++; $display("FAIL pxcol d=%0d k=%0d got %0d want %0d", d, k, w_col[d], k % 3); end
            n_tests++; if (w_pxlast[d] !== (k == 14)) begin n_fail++; $display("FAIL pxlast d=%0d k=%0d got %0d want %0d", d, k, w_pxlast[d], k == 14); end
            if (mode == 1 && k == 4 && stalls < 3) begin
                r = 1'b0;
                stalls++;
            end else if (mode == 2) begin
                r = 1'($urandom % 2);
            end else begin
                r = 1'b1;
            end
            if (noise) begin
                t_start[d] = 1'($urandom % 2);
                t_code[d]  = 4'd5;
            end
            t_ready[d] = r;
            if (r) k++;
            cyc++;
        end
        n_tests++; if (k != 15) begin n_fail++; $display("FAIL stream_timeout d=%0d got k=%0d want 15", d, k); end
        @(negedge clk);
        t_start[d] = 1'b0;
        t_ready[d] = 1'b0;
        n_tests++; if (w_busy[d] !== 1'b0) begin n_fail++; $display("FAIL end_busy d=%0d got %0d want 0", d, w_busy[d]); end
        n_tests++; if (w_pxvalid[d] !== 1'b0) begin n_fail++; $display("FAIL end_valid d=%0d got %0d want 0", d, w_pxvalid[d]); end
        n_tests++; if (w_pxlast[d] !== 1'b0) begin n_fail++; $display("FAIL end_last d=%0d got %0d want 0", d, w_pxlast[d]); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_tests++; if (w_busy[d] !== 1'b0 || w_pxvalid[d] !== 1'b0 || w_pxlast[d] !== 1'b0 || w_px[d] !== 1'b0)
                    begin n_fail++; $display("FAIL reset_flags d=%0d got busy=%0d valid=%0d last=%0d px=%0d want all 0", d, w_busy[d], w_pxvalid[d], w_pxlast[d], w_px[d]); end
                n_tests++; if (w_row[d] !== 3'd0 || w_col[d] !== 2'd0)
                    begin n_fail++; $display("FAIL reset_rowcol d=%0d got %0d,%0d want 0,0", d, w_row[d], w_col[d]); end
                n_tests++; if (w_ra[d] !== 5'(dbase(d)))
                    begin n_fail++; $display("FAIL reset_ra d=%0d got %0d want %0d", d, w_ra[d], dbase(d)); end
            end
        end
    endtask

    task automatic test_single;
        int cyc;
        run_glyph(0, 4'd3, 0, 1'b0, cyc);
        n_tests++; if (cyc != 15) begin n_fail++; $display("FAIL single_cycles got %0d want 15", cyc); end
    endtask

    task automatic test_backpressure;
        int cyc;
        run_glyph(0, 4'd3, 1, 1'b0, cyc);
        n_tests++; if (cyc != 18) begin n_fail++; $display("FAIL stall_cycles got %0d want 18", cyc); end
    endtask

    task automatic test_wrap;
        int cyc;
        run_glyph(1, 4'd1, 0, 1'b1, cyc);
        n_tests++; if (cyc != 15) begin n_fail++; $display("FAIL wrap_cycles got %0d want 15", cyc); end
    endtask

    task automatic test_invert;
        int cyc;
        run_glyph(2, 4'd3, 0, 1'b0, cyc);
    endtask

    task automatic test_back_to_back;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            run_glyph(0, 4'($urandom), 0, 1'b0, cyc);
            n_tests++; if (cyc != 15) begin n_fail++; $display("FAIL b2b_cycles i=%0d got %0d want 15", i, cyc); end
        end
    endtask

    task automatic test_random;
        int cyc;
        for (int i = 0; i < 20; i++) begin
            run_glyph(int'($urandom % 3), 4'($urandom), 2, 1'($urandom % 2), cyc);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        t_start[0] = 1'b1;
        t_code[0]  = 4'd3;
        t_ready[0] = 1'b1;
        @(negedge clk);
        t_start[0] = 1'b0;
        @(negedge clk);
        repeat (8) @(negedge clk);
        n_tests++; if (w_pxvalid[0] !== 1'b1 || w_row[0] !== 3'd2 || w_col[0] !== 2'd1)
            begin n_fail++; $display("FAIL prereset_pos got valid=%0d row=%0d col=%0d want 1,2,1", w_pxvalid[0], w_row[0], w_col[0]); end
        reset = 1'b1;
        #1;
        n_tests++; if (w_busy[0] !== 1'b0 || w_pxvalid[0] !== 1'b0 || w_pxlast[0] !== 1'b0 || w_px[0] !== 1'b0)
            begin n_fail++; $display("FAIL async_flags got busy=%0d valid=%0d last=%0d px=%0d want all 0", w_busy[0], w_pxvalid[0], w_pxlast[0], w_px[0]); end
        n_tests++; if (w_row[0] !== 3'd0 || w_col[0] !== 2'd0 || w_ra[0] !== 5'd0)
            begin n_fail++; $display("FAIL async_rowcol got row=%0d col=%0d ra=%0d want 0,0,0", w_row[0], w_col[0], w_ra[0]); end
        t_ready[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_glyph(0, 4'd3, 0, 1'b0, cyc);
        n_tests++; if (cyc != 15) begin n_fail++; $display("FAIL post_reset_cycles got %0d want 15", cyc); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hFF;
        rom[1] = 8'h00;
        rom[6] = 8'hA5;
        rom[7] = 8'h3C;
        t_start = 3'd0;
        t_ready = 3'd0;
        for (int i = 0; i < 3; i++) t_code[i] = 4'd0;
        reset = 1'b1;
        test_reset;
        test_single;
        test_backpressure;
        test_wrap;
        test_invert;
        test_back_to_back;
        test_random;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
